// File: rtl/dmem_access_unit.sv
// Load/store initiator for a doubleword-only data memory: extracts and extends
// sub-doubleword loads, performs read-modify-write for narrow stores, and flags range errors.
`timescale 1ns/1ps

module dmem_access_unit #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_error,
    output logic [63:0] mem_address,
    output logic [63:0] mem_write_data,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [63:0] mem_read_data
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    // Highest legal doubleword start address; compared unsigned over all 64 bits.
    localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES - 8);

    logic [1:0]  state;
    logic [63:0] addr_q;
    logic [63:0] data_q;
    logic [2:0]  funct3_q;
    logic        is_store_q;
    logic [63:0] resp_rdata_q;
    logic        resp_error_q;

    logic        req_bad;
    logic [63:0] size_mask;
    logic [63:0] load_ext;
    logic [63:0] merged;

    assign req_bad = (req_is_store ? req_funct3[2] : (req_funct3 == 3'b111))
                   || (req_addr > LAST_ADDR);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        size_mask = '1;
        case (funct3_q[1:0])
            2'd0:    size_mask = 64'h0000_0000_0000_00FF;
            2'd1:    size_mask = 64'h0000_0000_0000_FFFF;
            2'd2:    size_mask = 64'h0000_0000_FFFF_FFFF;
            default: size_mask = '1;
        endcase
    end

    always_comb begin
        load_ext = mem_read_data & size_mask;
        if (!funct3_q[2]) begin
            case (funct3_q[1:0])
                2'd0:    load_ext = {{56{mem_read_data[7]}},  mem_read_data[7:0]};
                2'd1:    load_ext = {{48{mem_read_data[15]}}, mem_read_data[15:0]};
                2'd2:    load_ext = {{32{mem_read_data[31]}}, mem_read_data[31:0]};
                default: load_ext = mem_read_data;
            endcase
        end
    end

    // Narrow store: replace the low bytes of the fetched doubleword, keep the rest.
    assign merged = (mem_read_data & ~size_mask) | (data_q & size_mask);

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state        <= S_IDLE;
            addr_q       <= '0;
            data_q       <= '0;
            funct3_q     <= '0;
            is_store_q   <= 1'b0;
            resp_rdata_q <= '0;
            resp_error_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q     <= req_addr;
                        data_q     <= req_wdata;
                        funct3_q   <= req_funct3;
                        is_store_q <= req_is_store;
                        if (req_bad) begin
                            resp_error_q <= 1'b1;
                            resp_rdata_q <= '0;
                            state        <= S_RESP;
                        end else if (req_is_store && req_funct3[1:0] == 2'b11) begin
                            state <= S_WRITE;
                        end else begin
                            state <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (is_store_q) begin
                        data_q <= merged;
                        state  <= S_WRITE;
                    end else begin
                        resp_rdata_q <= load_ext;
                        resp_error_q <= 1'b0;
                        state        <= S_RESP;
                    end
                end
                S_WRITE: begin
                    resp_rdata_q <= '0;
                    resp_error_q <= 1'b0;
                    state        <= S_RESP;
                end
                default: begin
                    if (resp_ready) state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready      = (state == S_IDLE);
    assign resp_valid     = (state == S_RESP);
    assign resp_rdata     = resp_rdata_q;
    assign resp_error     = resp_error_q;

    // Gating with reset guarantees nothing commits to memory while reset is asserted.
    assign mem_read       = (state == S_READ)  && !reset;
    assign mem_write      = (state == S_WRITE) && !reset;
    assign mem_address    = (state == S_READ || state == S_WRITE) ? addr_q : '0;
    assign mem_write_data = (state == S_WRITE) ? data_q : '0;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Self-checking bench for dmem_access_unit: attached byte memory, byte-level reference
// model, directed scenarios and randomized loads/stores.
`timescale 1ns/1ps

module tb_dmem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_error;
    logic [63:0] mem_address;
    logic [63:0] mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_read_data;

    int checks = 0;
    int errors = 0;
    int touch_cnt = 0;

    logic [7:0] mem     [0:1023];
    logic [7:0] ref_mem [0:1023];

    dmem_access_unit #(.MEM_BYTES(1024)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_error(resp_error), .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // Attached memory: combinational read, write on the rising edge.
    always_comb begin
        mem_read_data = '0;
        if (mem_read && mem_address <= 64'd1016)
            for (int i = 0; i < 8; i++)
                mem_read_data[8*i +: 8] = mem[mem_address[9:0] + 10'(i)];
    end

    always @(posedge clk) begin
        if (mem_write && mem_address <= 64'd1016)
            for (int i = 0; i < 8; i++)
                mem[mem_address[9:0] + 10'(i)] <= mem_write_data[8*i +: 8];
        if (mem_read || mem_write) touch_cnt <= touch_cnt + 1;
    end

    // ---------------- reference model ----------------
    function automatic logic is_legal(input logic st, input logic [2:0] f3, input logic [63:0] a);
        if (st && f3 > 3'd3) return 1'b0;
        if (!st && f3 == 3'd7) return 1'b0;
        return a <= 64'd1016;
    endfunction

    function automatic int exp_latency(input logic st, input logic [2:0] f3, input logic [63:0] a);
        if (!is_legal(st, f3, a)) return 1;
        if (!st || f3 == 3'd3) return 2;
        return 3;
    endfunction

    function automatic logic [63:0] exp_load(input logic [2:0] f3, input logic [63:0] a);
        int n;
        int base;
        logic [63:0] v;
        n = 1 << f3[1:0];
        base = int'(a[9:0]);
        v = '0;
        for (int i = 0; i < n; i++) v = v | (64'(ref_mem[base + i]) << (8 * i));
        if (!f3[2] && n < 8 && v[8*n-1]) v = v | (~64'd0 << (8 * n));
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [63:0] a, input logic [63:0] wd);
        int n;
        int base;
        n = 1 << f3[1:0];
        base = int'(a[9:0]);
        for (int i = 0; i < n; i++) ref_mem[base + i] = wd[8*i +: 8];
    endtask

    // One complete transaction; returns observed response, latency and memory-access count.
    task automatic do_req(input logic st, input logic [2:0] f3, input logic [63:0] a,
                          input logic [63:0] wd, output logic [63:0] rd, output logic er,
                          output int lat, output int touches);
        int t0;
        @(negedge clk);
        req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        t0 = touch_cnt;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = resp_rdata; er = resp_error; touches = touch_cnt - t0;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        if (st && is_legal(st, f3, a)) ref_store(f3, a, wd);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        reset = 1'b1; req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'd3;
        req_addr = 64'h8; req_wdata = '1; resp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (resp_valid !== 1'b0 || resp_rdata !== 64'd0 || resp_error !== 1'b0) begin
            errors++;
            $display("FAIL reset_resp: got valid=%b rdata=%h err=%b, want 0/0/0", resp_valid, resp_rdata, resp_error);
        end
        checks++;
        if (mem_read !== 1'b0 || mem_write !== 1'b0 || mem_address !== 64'd0 || mem_write_data !== 64'd0) begin
            errors++;
            $display("FAIL reset_mem: got rd=%b wr=%b addr=%h wdata=%h, want all 0", mem_read, mem_write, mem_address, mem_write_data);
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b want 1", req_ready);
        end
        req_valid = 1'b0;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_sd_ld;
        logic [63:0] rd; logic er; int lat, tc;
        do_req(1'b1, 3'd3, 64'h10, 64'h8877665544332211, rd, er, lat, tc);
        checks++;
        if (lat !== 2 || er !== 1'b0 || rd !== 64'd0) begin
            errors++;
            $display("FAIL sd_resp: got lat=%0d err=%b rdata=%h, want 2/0/0", lat, er, rd);
        end
        do_req(1'b0, 3'd3, 64'h10, 64'd0, rd, er, lat, tc);
        checks++;
        if (lat !== 2 || er !== 1'b0 || rd !== 64'h8877665544332211) begin
            errors++;
            $display("FAIL ld_after_sd: got lat=%0d err=%b rdata=%h, want 2/0/8877665544332211", lat, er, rd);
        end
    endtask

    task automatic test_sb_merge;
        logic [63:0] rd; logic er; int lat, tc;
        do_req(1'b1, 3'd0, 64'h12, 64'hFFFFFFFFFFFFFFAB, rd, er, lat, tc);
        checks++;
        if (lat !== 3 || er !== 1'b0) begin
            errors++;
            $display("FAIL sb_latency: got lat=%0d err=%b, want 3/0", lat, er);
        end
        do_req(1'b0, 3'd3, 64'h10, 64'd0, rd, er, lat, tc);
        checks++;
        if (rd !== 64'h8877665544AB2211) begin
            errors++;
            $display("FAIL sb_merge: got %h want 8877665544ab2211", rd);
        end
    endtask

    task automatic test_sizes;
        logic [63:0] rd; logic er; int lat, tc;
        logic [2:0]  f3s  [6] = '{3'd2, 3'd6, 3'd0, 3'd4, 3'd1, 3'd5};
        logic [63:0] exps [6] = '{64'hFFFFFFFFF0000080, 64'h00000000F0000080,
                                  64'hFFFFFFFFFFFFFF80, 64'h0000000000000080,
                                  64'h0000000000000080, 64'h0000000000000080};
        do_req(1'b1, 3'd2, 64'h20, 64'h00000000F0000080, rd, er, lat, tc);
        for (int i = 0; i < 6; i++) begin
            do_req(1'b0, f3s[i], 64'h20, 64'd0, rd, er, lat, tc);
            checks++;
            if (rd !== exps[i] || er !== 1'b0) begin
                errors++;
                $display("FAIL size_f3_%0d: got %h err=%b want %h", f3s[i], rd, er, exps[i]);
            end
        end
    endtask

    task automatic test_errors;
        logic [63:0] rd; logic er; int lat, tc;
        logic        sts  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        logic [2:0]  f3s  [5] = '{3'd3, 3'd3, 3'd3, 3'd7, 3'd4};
        logic [63:0] adrs [5] = '{64'd1017, 64'hFFFFFFFFFFFFFFFC, 64'd1016, 64'h10, 64'h10};
        logic        eerr [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 5; i++) begin
            do_req(sts[i], f3s[i], adrs[i], 64'hDEAD, rd, er, lat, tc);
            checks++;
            if (er !== eerr[i] || (eerr[i] && (rd !== 64'd0 || lat !== 1 || tc !== 0))
                || (!eerr[i] && lat !== 2)) begin
                errors++;
                $display("FAIL err_case_%0d: got err=%b rdata=%h lat=%0d mem_acc=%0d, want err=%b",
                         i, er, rd, lat, tc, eerr[i]);
            end
        end
    endtask

    task automatic test_stall;
        logic [63:0] rd; logic er; int lat, tc;
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'd3; req_addr = 64'h10;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            // A competing SD that must be ignored while the response is pending.
            req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'd3; req_wdata = 64'h0BAD0BAD0BAD0BAD;
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== 64'h8877665544AB2211 || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_cycle_%0d: got valid=%b rdata=%h ready=%b, want 1/8877665544ab2211/0",
                         c, resp_valid, resp_rdata, req_ready);
            end
        end
        @(negedge clk);
        req_valid = 1'b0; resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: got ready=%b valid=%b, want 1/0", req_ready, resp_valid);
        end
        do_req(1'b0, 3'd3, 64'h10, 64'd0, rd, er, lat, tc);
        checks++;
        if (rd !== 64'h8877665544AB2211) begin
            errors++;
            $display("FAIL stall_ignored_req: got %h want 8877665544ab2211", rd);
        end
    endtask

    task automatic test_reset_mid;
        logic [63:0] rd; logic er; int lat, tc;
        do_req(1'b1, 3'd3, 64'h30, 64'h1111111111111111, rd, er, lat, tc);
        @(negedge clk);
        req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'd1; req_addr = 64'h30; req_wdata = 64'hBEEF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (mem_write !== 1'b1) begin
            errors++;
            $display("FAIL rmw_write_phase: got mem_write=%b want 1", mem_write);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (mem_write !== 1'b0) begin
            errors++;
            $display("FAIL reset_blocks_write: got mem_write=%b want 0", mem_write);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || resp_rdata !== 64'd0 || resp_error !== 1'b0 ||
            mem_read !== 1'b0 || mem_write !== 1'b0 || mem_address !== 64'd0) begin
            errors++;
            $display("FAIL after_reset: got valid=%b rdata=%h err=%b rd=%b wr=%b addr=%h, want all 0",
                     resp_valid, resp_rdata, resp_error, mem_read, mem_write, mem_address);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL abandoned_resp: got resp_valid=%b want 0", resp_valid);
        end
        do_req(1'b0, 3'd3, 64'h30, 64'd0, rd, er, lat, tc);
        checks++;
        if (rd !== 64'h1111111111111111) begin
            errors++;
            $display("FAIL mem_untouched: got %h want 1111111111111111", rd);
        end
    endtask

    task automatic test_random;
        logic [63:0] rd, a, wd, exp_rd; logic er, st, exp_er; logic [2:0] f3; int lat, tc, sel;
        for (int n = 0; n < 300; n++) begin
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            sel = int'($urandom_range(0, 9));
            if (sel < 8)       a = 64'($urandom_range(0, 1016));
            else if (sel == 8) a = 64'($urandom_range(1017, 1023));
            else               a = {$urandom, $urandom};
            wd = {$urandom, $urandom};
            exp_er = !is_legal(st, f3, a);
            exp_rd = (exp_er || st) ? 64'd0 : exp_load(f3, a);
            do_req(st, f3, a, wd, rd, er, lat, tc);
            checks++;
            if (rd !== exp_rd || er !== exp_er || lat !== exp_latency(st, f3, a)) begin
                errors++;
                $display("FAIL rand_%0d st=%b f3=%0d addr=%h: got rdata=%h err=%b lat=%0d, want %h/%b/%0d",
                         n, st, f3, a, rd, er, lat, exp_rd, exp_er, exp_latency(st, f3, a));
            end
        end
        // Read back a sweep of doublewords so every stored byte is compared at least once.
        for (int b = 0; b <= 1016; b += 8) begin
            exp_rd = exp_load(3'd3, 64'(b));
            do_req(1'b0, 3'd3, 64'(b), 64'd0, rd, er, lat, tc);
            checks++;
            if (rd !== exp_rd) begin
                errors++;
                $display("FAIL sweep_%0d: got %h want %h", b, rd, exp_rd);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 8'h00;
            ref_mem[i] = 8'h00;
        end
        req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = '0;
        req_addr = '0; req_wdata = '0; resp_ready = 1'b0; reset = 1'b1;

        test_reset();
        test_sd_ld();
        test_sb_merge();
        test_sizes();
        test_errors();
        test_stall();
        test_reset_mid();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_access_unit.md
Name: dmem_access_unit

Overview:
- Initiator side of the data-memory interface; sits between the execute/memory stage and the 1 KB byte-addressed data memory.
- The memory only moves 8-byte little-endian doublewords. It writes on the clock edge and reads combinationally while its read enable is high.
- This unit accepts RV64 load/store requests over a valid/ready handshake and handles the access sizes the memory cannot:
  - loads: byte/half/word extraction with sign or zero extension;
  - sub-doubleword stores: read-modify-write;
  - range errors.

Parameters:
MEM_BYTES, 1024, size of the attached memory in bytes; legal addresses satisfy addr <= MEM_BYTES-8.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  synchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  unit can accept a request (high only in IDLE).
req_is_store  input  1  1 = store, 0 = load.
req_funct3  input  3  RV64 funct3. Loads: 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU. Stores: 000 SB, 001 SH, 010 SW, 011 SD.
req_addr  input  64  byte address; need not be aligned.
req_wdata  input  64  store data; the low 1/2/4/8 bytes are used.
resp_valid  output  1  response present.
resp_ready  input  1  consumer accepts the response.
resp_rdata  output  64  extended load data; 0 for stores and errors.
resp_error  output  1  out-of-range address or illegal funct3.
mem_address  output  64  to memory address.
mem_write_data  output  64  to memory write_data.
mem_read  output  1  to memory mem_read.
mem_write  output  1  to memory mem_write.
mem_read_data  input  64  from memory read_data.

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset is synchronous and active-high on port reset.
  - Reset forces state IDLE. Registered outputs reset to 0: resp_valid, resp_rdata, resp_error. Internal address/data/size registers also reset to 0.
- Memory-side outputs:
  - mem_read and mem_write are combinational from state, ANDed with !reset, so no memory write commits in a cycle where reset is high.
  - mem_address and mem_write_data are 0 outside READ/WRITE.
- State IDLE:
  - req_ready=1.
  - On req_valid, latch addr, wdata, funct3 and is_store.
  - Error check is a full 64-bit unsigned compare. Illegal funct3 = 111 for a load, or funct3[2]=1 for a store. Out-of-range = addr > MEM_BYTES-8.
  - If illegal funct3 or out-of-range: go to RESP with resp_error=1, resp_rdata=0, and no memory access.
  - Else if SD: go to WRITE with merged data = wdata.
  - Else (any load, SB, SH, SW): go to READ.
- State READ:
  - mem_read=1, mem_address=addr.
  - Register mem_read_data at the cycle end. The memory is combinational, so its data is valid in the same cycle.
  - Load: go to RESP. resp_rdata is the low N bytes, where N = 1/2/4/8 from funct3[1:0]. Sign-extend when funct3[2]=0, zero-extend when funct3[2]=1.
  - Store: go to WRITE. Merged data = memory doubleword with the low N bytes replaced by wdata[8N-1:0]; upper bytes are preserved.
- State WRITE:
  - mem_write=1, mem_address=addr, mem_write_data=merged.
  - The memory commits at this edge. Go to RESP with resp_rdata=0, resp_error=0.
- State RESP:
  - resp_valid=1. resp_rdata and resp_error are held stable until resp_ready.
  - On resp_ready, go to IDLE. resp_valid drops on the next cycle.
  - A new request can be accepted no earlier than the cycle after the handshake, so throughput is 1 request per 3 to 4 cycles minimum.
- Latency, counted from the accept edge to resp_valid high:
  - error: 1 cycle;
  - load or SD: 2 cycles;
  - SB/SH/SW: 3 cycles.
- Simultaneous events: req_valid during READ/WRITE/RESP is ignored because req_ready=0. The requester must hold its request until accepted.
- Reset mid-operation: the access is abandoned and no response is produced.
  - Reset high in the WRITE cycle means no write occurs.
  - Reset high in the READ cycle means memory is untouched.
- Wrap-around: addr near 2^64 must fail the range check (no 64-bit overflow in the compare); no address arithmetic wraps.

Test Plan:
1. SD addr=0x10 data=0x8877665544332211, then LD 0x10 -> LD response 0x8877665544332211, resp_error=0. Both the SD and LD responses arrive 2 cycles after accept.
2. After (1), SB addr=0x12 data=0xFFFFFFFFFFFFFFAB, then LD 0x10 -> 0x8877665544AB2211. The SB response arrives 3 cycles after accept; bytes 0x13..0x17 are unchanged.
3. SW addr=0x20 data=0x00000000F0000080, then LW 0x20 -> 0xFFFFFFFFF0000080. LWU -> 0x00000000F0000080. LB -> 0xFFFFFFFFFFFFFF80. LBU -> 0x0000000000000080. LH/LHU 0x20 -> 0x0000000000000080.
4. LD addr=1017, then LD addr=0xFFFFFFFFFFFFFFFC -> resp_error=1, resp_rdata=0, 1 cycle after accept, mem_read/mem_write never asserted. LD addr=1016 -> resp_error=0. Load funct3=111 -> resp_error=1.
5. Hold resp_ready=0 for 5 cycles on an LD -> resp_valid and resp_rdata stable, req_ready=0, new req_valid ignored. After the handshake, req_ready=1 the next cycle.
6. Start SH addr=0x30 data=0xBEEF over existing 0x1111111111111111 and assert reset in the WRITE cycle -> mem_write=0 that cycle, no response. LD 0x30 -> 0x1111111111111111, and all outputs are 0 after reset.
